// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO interconnect: FSM states, errno codes,
// the default region tag map and the latched request payload.
package mmio_pkg;

  localparam int unsigned TAG_W   = 12;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned ERRNO_W = 3;
  localparam int unsigned TMO_W   = 16;
  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_ACCESS = 2'd1;
  localparam logic [STATE_W-1:0] ST_RESP   = 2'd2;

  localparam logic [ERRNO_W-1:0] ERR_NONE          = 3'd0;
  localparam logic [ERRNO_W-1:0] ERR_INVALID_READ  = 3'd1;
  localparam logic [ERRNO_W-1:0] ERR_INVALID_WRITE = 3'd2;
  localparam logic [ERRNO_W-1:0] ERR_TIMEOUT       = 3'd3;

  // Region map of the existing system (addr[31:20]).
  localparam logic [TAG_W-1:0] TAG_DATA     = 12'h001;
  localparam logic [TAG_W-1:0] TAG_VGA_INFO = 12'h002;
  localparam logic [TAG_W-1:0] TAG_VGA_LINE = 12'h003;
  localparam logic [TAG_W-1:0] TAG_KBD_CODE = 12'h004;
  localparam logic [TAG_W-1:0] TAG_KBD_DOWN = 12'h005;
  localparam logic [TAG_W-1:0] TAG_HEX      = 12'h006;
  localparam logic [TAG_W-1:0] TAG_SW       = 12'h007;
  localparam logic [TAG_W-1:0] TAG_LED      = 12'h008;

  // Full 8-slave table in SLV_TAG packing order (entry 0 in the low bits).
  localparam logic [8*TAG_W-1:0] DEFAULT_SLV_TAGS = {
    TAG_LED, TAG_SW, TAG_HEX, TAG_KBD_DOWN,
    TAG_KBD_CODE, TAG_VGA_LINE, TAG_VGA_INFO, TAG_DATA
  };

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [OP_W-1:0]   op;
  } mmio_req_t;

  // Region tag of a byte address.
  function automatic logic [TAG_W-1:0] addr_tag(input logic [DATA_W-1:0] addr);
    return addr[DATA_W-1:DATA_W-TAG_W];
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Free-running cycle / us / ms / s counters derived from CLK_HZ by a
// prescaler chain. Only instantiated when MMIO_TIMER_EN is defined.
module mmio_timer
  import mmio_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        sel_i,
  output logic [DATA_W-1:0] value_c
);

  localparam int unsigned   CYC_PER_US = (CLK_HZ >= 1000000) ? (CLK_HZ / 1000000) : 1;
  localparam logic [31:0]   US_LAST    = 32'(CYC_PER_US - 1);
  localparam logic [9:0]    K_LAST     = 10'd999;

  logic [31:0]       us_pre_q, us_pre_d;
  logic [9:0]        ms_pre_q, ms_pre_d, s_pre_q, s_pre_d;
  logic [DATA_W-1:0] cyc_q, cyc_d, us_q, us_d, ms_q, ms_d, sec_q, sec_d;
  logic              us_tick_c, ms_tick_c, s_tick_c;

  // Prescaler chain: each stage advances on the terminal count of the one below.
  always_comb begin
    us_tick_c = (us_pre_q == US_LAST);
    ms_tick_c = us_tick_c && (ms_pre_q == K_LAST);
    s_tick_c  = ms_tick_c && (s_pre_q == K_LAST);
    cyc_d     = cyc_q + DATA_W'(1);
    us_pre_d  = us_tick_c ? 32'd0 : us_pre_q + 32'd1;
    ms_pre_d  = ms_pre_q;
    s_pre_d   = s_pre_q;
    us_d      = us_q;
    ms_d      = ms_q;
    sec_d     = sec_q;
    if (us_tick_c) begin
      us_d     = us_q + DATA_W'(1);
      ms_pre_d = ms_tick_c ? 10'd0 : ms_pre_q + 10'd1;
    end
    if (ms_tick_c) begin
      ms_d    = ms_q + DATA_W'(1);
      s_pre_d = s_tick_c ? 10'd0 : s_pre_q + 10'd1;
    end
    if (s_tick_c) begin
      sec_d = sec_q + DATA_W'(1);
    end
  end

  // Counter state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      us_pre_q <= '0;
      ms_pre_q <= '0;
      s_pre_q  <= '0;
      cyc_q    <= '0;
      us_q     <= '0;
      ms_q     <= '0;
      sec_q    <= '0;
    end else begin
      us_pre_q <= us_pre_d;
      ms_pre_q <= ms_pre_d;
      s_pre_q  <= s_pre_d;
      cyc_q    <= cyc_d;
      us_q     <= us_d;
      ms_q     <= ms_d;
      sec_q    <= sec_d;
    end
  end

  // Read-side select by addr[3:2].
  always_comb begin
    value_c = cyc_q;
    case (sel_i)
      2'd1:    value_c = us_q;
      2'd2:    value_c = ms_q;
      2'd3:    value_c = sec_q;
      default: value_c = cyc_q;
    endcase
  end

endmodule

// File: rtl/mmio_bus.sv
// MMIO interconnect: decodes addr[31:20] to one of NUM_SLV slaves, runs the
// valid/ready handshake with a per-access timeout, and hosts the errno
// register. Optional internal timer region: MMIO_TIMER_EN.
module mmio_bus
  import mmio_pkg::*;
#(
  parameter int unsigned             NUM_SLV   = 8,
  parameter logic [NUM_SLV*TAG_W-1:0] SLV_TAG  = '0,
  parameter logic [TAG_W-1:0]        ERR_TAG   = 12'hFFF,
  parameter int unsigned             TIMEOUT   = 255,
  parameter int unsigned             CLK_HZ    = 50000000,
  parameter logic [TAG_W-1:0]        TIMER_TAG = 12'hFFE
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [DATA_W-1:0]           req_addr,
  input  logic [DATA_W-1:0]           req_wdata,
  input  logic [OP_W-1:0]             req_op,
  output logic                        rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic [NUM_SLV-1:0]          slv_sel,
  output logic                        slv_we,
  output logic [DATA_W-1:0]           slv_addr,
  output logic [DATA_W-1:0]           slv_wdata,
  output logic [OP_W-1:0]             slv_op,
  input  logic [NUM_SLV*DATA_W-1:0]   slv_rdata,
  input  logic [NUM_SLV-1:0]          slv_ready
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic [NUM_SLV-1:0] sel_q, sel_d;
  logic               we_q, we_d;
  mmio_req_t          req_q, req_d;
  logic [ERRNO_W-1:0] errno_q, errno_d;
  logic [TMO_W-1:0]   cnt_q, cnt_d, cnt_inc_c;

  logic [TAG_W-1:0]   tag_c;
  logic               slv_hit_c;
  logic [NUM_SLV-1:0] slv_onehot_c;
  logic               sel_ready_c;
  logic [DATA_W-1:0]  sel_rdata_c;
  logic [DATA_W-1:0]  timer_value_c;

`ifdef MMIO_TIMER_EN
  mmio_timer #(.CLK_HZ(CLK_HZ)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .sel_i   (req_addr[3:2]),
    .value_c (timer_value_c)
  );
`else
  // Timer configuration has no effect in this build; TIMER_TAG is a plain miss.
  logic unused_timer_cfg;
  assign timer_value_c    = '0;
  assign unused_timer_cfg = ^{32'(CLK_HZ), TIMER_TAG, timer_value_c};
`endif

  // Tag decode against the slave table; lowest matching index wins.
  always_comb begin
    tag_c        = addr_tag(req_addr);
    slv_hit_c    = 1'b0;
    slv_onehot_c = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (!slv_hit_c && (tag_c == SLV_TAG[i*TAG_W +: TAG_W])) begin
        slv_hit_c       = 1'b1;
        slv_onehot_c[i] = 1'b1;
      end
    end
  end

  // Completion and read data of the currently selected slave only.
  always_comb begin
    sel_ready_c = |(slv_ready & sel_q);
    sel_rdata_c = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (sel_q[i]) begin
        sel_rdata_c = sel_rdata_c | slv_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and output logic of the IDLE / ACCESS / RESP sequencer.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    sel_d       = sel_q;
    we_d        = we_q;
    req_d       = req_q;
    errno_d     = errno_q;
    cnt_inc_c   = cnt_q + TMO_W'(1);
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          req_d       = '{we: req_we, addr: req_addr, wdata: req_wdata, op: req_op};
          req_ready_d = 1'b0;
          if (slv_hit_c) begin
            state_d = ST_ACCESS;
            sel_d   = slv_onehot_c;
            we_d    = req_we;
            cnt_d   = '0;
          end else if (tag_c == ERR_TAG) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            if (req_we) begin
              errno_d     = req_wdata[ERRNO_W-1:0];
              rsp_rdata_d = '0;
            end else begin
              rsp_rdata_d = DATA_W'(errno_q);
            end
`ifdef MMIO_TIMER_EN
          end else if (tag_c == TIMER_TAG) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            if (req_we) begin
              errno_d     = ERR_INVALID_WRITE;
              rsp_err_d   = 1'b1;
              rsp_rdata_d = '0;
            end else begin
              rsp_err_d   = 1'b0;
              rsp_rdata_d = timer_value_c;
            end
`endif
          end else begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            errno_d     = req_we ? ERR_INVALID_WRITE : ERR_INVALID_READ;
          end
        end
      end

      ST_ACCESS: begin
        req_ready_d = 1'b0;
        if (sel_ready_c) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = req_q.we ? '0 : sel_rdata_c;
          sel_d       = '0;
          we_d        = 1'b0;
        end else if (cnt_inc_c == TMO_W'(TIMEOUT)) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          errno_d     = ERR_TIMEOUT;
          sel_d       = '0;
          we_d        = 1'b0;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end

      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        sel_d       = '0;
        we_d        = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      req_q       <= '0;
      errno_q     <= ERR_NONE;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      req_q       <= req_d;
      errno_q     <= errno_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign slv_sel   = sel_q;
  assign slv_we    = we_q;
  assign slv_addr  = req_q.addr;
  assign slv_wdata = req_q.wdata;
  assign slv_op    = req_q.op;

endmodule

// File: tb/tb_mmio_bus.sv
// Directed bench for mmio_bus: a vector table of single accesses plus
// hand-written sequences for wait states, reset mid-access and the timer.
module tb_mmio_bus;
  import mmio_pkg::*;

  localparam int unsigned NS = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        req_op;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [NS-1:0]     slv_sel;
  logic              slv_we;
  logic [31:0]       slv_addr;
  logic [31:0]       slv_wdata;
  logic [2:0]        slv_op;
  logic [NS*32-1:0]  slv_rdata;
  logic [NS-1:0]     slv_ready;

  int checks   = 0;
  int failures = 0;

  // Slave 3 shares slave 1's tag to exercise lowest-index priority.
  mmio_bus #(
    .NUM_SLV   (NS),
    .SLV_TAG   ({TAG_VGA_INFO, TAG_KBD_CODE, TAG_VGA_INFO, TAG_DATA}),
    .ERR_TAG   (12'hFFF),
    .TIMEOUT   (10),
    .CLK_HZ    (1000000),
    .TIMER_TAG (12'hFFE)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .slv_sel   (slv_sel),
    .slv_we    (slv_we),
    .slv_addr  (slv_addr),
    .slv_wdata (slv_wdata),
    .slv_op    (slv_op),
    .slv_rdata (slv_rdata),
    .slv_ready (slv_ready)
  );

  always #5 clock = ~clock;

  initial begin
`ifdef MMIO_TIMER_EN
    #40_000_000;
`else
    #1_000_000;
`endif
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  // One access: drive in an IDLE cycle, report cycle-1 select, latency to
  // rsp_valid (cycles after acceptance, -1 on no response) and whether the
  // strobe was a single cycle followed by req_ready.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output logic [NS-1:0] sel1, output logic tail_ok);
    @(negedge clock);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_op    = 3'b010;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    sel1 = slv_sel;
    lat  = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    rdata   = rsp_rdata;
    err     = rsp_err;
    tail_ok = 1'b0;
    if (!rsp_valid) begin
      lat = -1;
    end else begin
      @(negedge clock);
      tail_ok = (rsp_valid === 1'b0) && (req_ready === 1'b1);
    end
  endtask

  typedef struct packed {
    logic          we;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [NS-1:0] ready;
    logic [NS-1:0] exp_sel;
    logic          exp_err;
    logic [31:0]   exp_rdata;
    int            exp_lat;
  } vec_t;

  localparam int NV = 16;
  vec_t vec [NV];

  logic [31:0]   r_rdata;
  logic          r_err;
  int            r_lat;
  logic [NS-1:0] r_sel;
  logic          r_tail;
  logic          hold_ok;
  int            pulses;

  initial begin
    //        we    addr          wdata         rdy    sel    err   rdata         lat
    vec[0]  = '{1'b0, 32'h0040_0010, 32'h0,        4'hF, 4'h4, 1'b0, 32'hDEAD_BEEF, 2};
    vec[1]  = '{1'b0, 32'hFFF0_0000, 32'h0,        4'hF, 4'h0, 1'b0, 32'h0,         1};
    vec[2]  = '{1'b0, 32'h0020_0004, 32'h0,        4'hF, 4'h2, 1'b0, 32'hA000_0001, 2};
    vec[3]  = '{1'b1, 32'h0010_0000, 32'h5,        4'hF, 4'h1, 1'b0, 32'h0,         2};
    vec[4]  = '{1'b0, 32'h7AB0_0000, 32'h0,        4'hF, 4'h0, 1'b1, 32'h0,         1};
    vec[5]  = '{1'b0, 32'hFFF0_0000, 32'h0,        4'hF, 4'h0, 1'b0, 32'h1,         1};
    vec[6]  = '{1'b0, 32'h0010_0000, 32'h0,        4'hF, 4'h1, 1'b0, 32'hA000_0000, 2};
    vec[7]  = '{1'b0, 32'hFFF0_0004, 32'h0,        4'hF, 4'h0, 1'b0, 32'h1,         1};
    vec[8]  = '{1'b1, 32'hFFF0_0000, 32'h6,        4'hF, 4'h0, 1'b0, 32'h0,         1};
    vec[9]  = '{1'b0, 32'hFFF0_0000, 32'h0,        4'hF, 4'h0, 1'b0, 32'h6,         1};
    vec[10] = '{1'b1, 32'hFFE0_0000, 32'hFFFF,     4'hF, 4'h0, 1'b1, 32'h0,         1};
    vec[11] = '{1'b0, 32'hFFF0_0000, 32'h0,        4'hF, 4'h0, 1'b0, 32'h2,         1};
    vec[12] = '{1'b0, 32'h0020_0000, 32'h0,        4'h8, 4'h2, 1'b1, 32'h0,         11};
    vec[13] = '{1'b0, 32'hFFF0_0000, 32'h0,        4'hF, 4'h0, 1'b0, 32'h3,         1};
    vec[14] = '{1'b1, 32'hFFF0_0000, 32'hFFFF_FFF8, 4'hF, 4'h0, 1'b0, 32'h0,        1};
    vec[15] = '{1'b0, 32'hFFF0_0000, 32'h0,        4'hF, 4'h0, 1'b0, 32'h0,         1};

    slv_rdata = {32'hA000_0003, 32'hDEAD_BEEF, 32'hA000_0001, 32'hA000_0000};
    slv_ready = '0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_op    = '0;
    reset     = 1'b1;

    // Reset values
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err",   32'(rsp_err), 32'h0);
    chk("rst_slv_sel",   32'(slv_sel), 32'h0);
    chk("rst_slv_bus",   {slv_addr[15:0] | slv_wdata[15:0], 11'h0, slv_we, 1'b0, slv_op}, 32'h0);
    reset = 1'b0;

    // Vector table
    for (int i = 0; i < NV; i++) begin
      slv_ready = vec[i].ready;
      do_req(vec[i].we, vec[i].addr, vec[i].wdata, r_rdata, r_err, r_lat, r_sel, r_tail);
      chk($sformatf("vec%0d_sel", i),   32'(r_sel), 32'(vec[i].exp_sel));
      chk($sformatf("vec%0d_lat", i),   32'(r_lat), 32'(vec[i].exp_lat));
      chk($sformatf("vec%0d_err", i),   32'(r_err), 32'(vec[i].exp_err));
      chk($sformatf("vec%0d_rdata", i), r_rdata,    vec[i].exp_rdata);
      chk($sformatf("vec%0d_tail", i),  32'(r_tail), 32'h1);
    end

    // Wait states: slave 0 ready in its 5th ACCESS cycle
    slv_ready = '0;
    @(negedge clock);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h0010_0008;
    req_wdata = 32'h0000_1234;
    req_op    = 3'd5;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    req_wdata = 32'h0;
    hold_ok   = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge clock);
      if (slv_sel !== 4'b0001 || slv_wdata !== 32'h1234 || slv_we !== 1'b1 ||
          slv_addr !== 32'h0010_0008 || slv_op !== 3'd5 || rsp_valid !== 1'b0 ||
          req_ready !== 1'b0) hold_ok = 1'b0;
      if (k == 5) slv_ready = 4'b0001;
    end
    chk("wait_hold", 32'(hold_ok), 32'h1);
    @(negedge clock);
    slv_ready = '0;
    chk("wait_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("wait_rsp_err",   32'(rsp_err), 32'h0);
    chk("wait_rsp_rdata", rsp_rdata, 32'h0);
    chk("wait_sel_drop",  {27'h0, slv_we, slv_sel}, 32'h0);
    @(negedge clock);
    chk("wait_one_pulse", {30'h0, rsp_valid, req_ready}, 32'h1);

    // Miss then clear
    slv_ready = 4'hF;
    do_req(1'b1, 32'h7AB0_0000, 32'h1, r_rdata, r_err, r_lat, r_sel, r_tail);
    chk("miss_w_err", 32'(r_err), 32'h1);
    do_req(1'b0, 32'hFFF0_0000, 32'h0, r_rdata, r_err, r_lat, r_sel, r_tail);
    chk("miss_w_errno", r_rdata, 32'h2);
    do_req(1'b1, 32'hFFF0_0000, 32'h0, r_rdata, r_err, r_lat, r_sel, r_tail);
    do_req(1'b0, 32'hFFF0_0000, 32'h0, r_rdata, r_err, r_lat, r_sel, r_tail);
    chk("clear_errno", r_rdata, 32'h0);

    // Reset mid-access
    do_req(1'b0, 32'h7AB0_0000, 32'h0, r_rdata, r_err, r_lat, r_sel, r_tail);
    slv_ready = '0;
    @(negedge clock);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0040_0000;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    chk("rstmid_pre_sel", 32'(slv_sel), 32'h4);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rstmid_sel",   32'(slv_sel), 32'h0);
    chk("rstmid_ready", 32'(req_ready), 32'h1);
    chk("rstmid_valid", 32'(rsp_valid), 32'h0);
    reset  = 1'b0;
    pulses = 0;
    repeat (15) begin
      @(negedge clock);
      if (rsp_valid) pulses++;
    end
    chk("rstmid_no_rsp", 32'(pulses), 32'h0);
    slv_ready = 4'hF;
    do_req(1'b0, 32'hFFF0_0000, 32'h0, r_rdata, r_err, r_lat, r_sel, r_tail);
    chk("rstmid_errno", r_rdata, 32'h0);

`ifdef MMIO_TIMER_EN
    // Timer region at 1 MHz: ms and s counters after 2.5 s
    repeat (2_500_000) @(posedge clock);
    do_req(1'b0, 32'hFFE0_000C, 32'h0, r_rdata, r_err, r_lat, r_sel, r_tail);
    chk("timer_s", r_rdata, 32'd2);
    chk("timer_s_err", 32'(r_err), 32'h0);
    do_req(1'b0, 32'hFFE0_0008, 32'h0, r_rdata, r_err, r_lat, r_sel, r_tail);
    checks++;
    if (r_rdata < 32'd2500 || r_rdata > 32'd2501) begin
      failures++;
      $display("FAIL timer_ms actual=%0d expected=2500..2501", r_rdata);
    end
`else
    // Timer tag is an ordinary miss without the timer
    do_req(1'b0, 32'hFFE0_0004, 32'h0, r_rdata, r_err, r_lat, r_sel, r_tail);
    chk("notimer_err", 32'(r_err), 32'h1);
    chk("notimer_rdata", r_rdata, 32'h0);
    do_req(1'b0, 32'hFFF0_0000, 32'h0, r_rdata, r_err, r_lat, r_sel, r_tail);
    chk("notimer_errno", r_rdata, 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
